key_debounce: RTL

KEY_DEBOUNCE -- requirements
Module: key_debounce

---
 rtl/key_debounce.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/key_debounce.sv
// Four-key push-button debouncer: per-key 2-flop synchronizer and a filter FSM
// producing a debounced level plus press, release and long-press pulses.
module key_debounce #(
  parameter logic [19:0] DEB_CNT  = 20'd999_999,
  parameter logic [25:0] LONG_CNT = 26'd49_999_999
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_n,
  output logic [3:0] key_state,
  output logic [3:0] key_press,
  output logic [3:0] key_release,
  output logic [3:0] key_long
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_FILT = 2'd1,
    DOWN       = 2'd2,
    REL_FILT   = 2'd3
  } state_t;

  logic [3:0] sync1_q;
  logic [3:0] sync2_q;

  // Synchronizer idles at 1 (released) so reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_key
    state_t      state_q, state_d;
    logic [19:0] dcnt_q, dcnt_d;
    logic [25:0] hcnt_q, hcnt_d;
    logic        long_done_q, long_done_d;
    logic        press_q, press_d;
    logic        rel_q, rel_d;
    logic        long_q, long_d;
    logic        held_q, held_d;
    logic        s2;

    assign s2 = sync2_q[k];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q     <= IDLE;
        dcnt_q      <= '0;
        hcnt_q      <= '0;
        long_done_q <= 1'b0;
        press_q     <= 1'b0;
        rel_q       <= 1'b0;
        long_q      <= 1'b0;
        held_q      <= 1'b0;
      end else begin
        state_q     <= state_d;
        dcnt_q      <= dcnt_d;
        hcnt_q      <= hcnt_d;
        long_done_q <= long_done_d;
        press_q     <= press_d;
        rel_q       <= rel_d;
        long_q      <= long_d;
        held_q      <= held_d;
      end
    end

    always_comb begin
      state_d     = state_q;
      dcnt_d      = dcnt_q;
      hcnt_d      = hcnt_q;
      long_done_d = long_done_q;
      press_d     = 1'b0;
      rel_d       = 1'b0;
      long_d      = 1'b0;

      // The hold counter runs through release filtering so a bounce does not
      // reset long-press timing.
      if ((state_q == DOWN || state_q == REL_FILT) && hcnt_q != LONG_CNT) begin
        hcnt_d = hcnt_q + 26'd1;
      end

      case (state_q)
        IDLE: begin
          if (!s2) begin
            state_d = PRESS_FILT;
            dcnt_d  = '0;
          end
        end
        PRESS_FILT: begin
          if (s2) begin
            state_d = IDLE;
            dcnt_d  = '0;
          end else if (dcnt_q != DEB_CNT) begin
            dcnt_d = dcnt_q + 20'd1;
          end else begin
            state_d     = DOWN;
            press_d     = 1'b1;
            hcnt_d      = '0;
            long_done_d = 1'b0;
          end
        end
        DOWN: begin
          if (s2) begin
            state_d = REL_FILT;
            dcnt_d  = '0;
          end
        end
        REL_FILT: begin
          if (!s2) begin
            state_d = DOWN;
          end else if (dcnt_q == DEB_CNT) begin
            state_d = IDLE;
            rel_d   = 1'b1;
          end else begin
            dcnt_d = dcnt_q + 20'd1;
          end
        end
        default: state_d = IDLE;
      endcase

      held_d = (state_d == DOWN) || (state_d == REL_FILT);

      // Long pulse fires once per press, when the saturated hold count is first seen.
      if (held_d && state_q != PRESS_FILT && hcnt_q == LONG_CNT && !long_done_q) begin
        long_d      = 1'b1;
        long_done_d = 1'b1;
      end
    end

    assign key_state[k]   = held_q;
    assign key_press[k]   = press_q;
    assign key_release[k] = rel_q;
    assign key_long[k]    = long_q;
  end

endmodule
